// File: rtl/led_pattern_engine.sv
// LED bank driver: rotate-left/right, bounce and binary-count patterns from a prescaled tick.
// Optional macro LED_PATTERN_GRAY_EN makes count mode present Gray code from a separate binary counter.
module led_pattern_engine #(
  parameter int LED_WIDTH   = 16,
  parameter int CLK_FREQ_HZ = 10_000_000,
  parameter int TICK_HZ     = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic [1:0]           speed_sel,
  input  logic                 step,
  output logic [LED_WIDTH-1:0] led_out,
  output logic                 tick_out
);

  localparam int PERIOD = CLK_FREQ_HZ / TICK_HZ;
  localparam int CW     = $clog2(PERIOD);

  localparam logic [1:0] MODE_ROL    = 2'd0;
  localparam logic [1:0] MODE_ROR    = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_COUNT  = 2'd3;

  typedef enum logic {DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1} dir_t;

  logic [CW-1:0] count;
  logic [CW-1:0] cur_max;
  logic [1:0]    mode_q;
  logic          step_q;
  dir_t          dir;
  logic          tick_int;
  logic          step_edge;
  logic          update;
  logic          reload;
  logic          led_onehot;

`ifdef LED_PATTERN_GRAY_EN
  logic [LED_WIDTH-1:0] cnt;
  logic [LED_WIDTH-1:0] cnt_inc;
  assign cnt_inc = cnt + LED_WIDTH'(1);
`endif

  // >= rather than == so a mid-count speed increase ticks on the next cycle.
  assign cur_max    = CW'((PERIOD >> speed_sel) - 1);
  assign tick_int   = enable && (count >= cur_max);
  assign step_edge  = step & ~step_q;
  assign update     = tick_int | step_edge;
  assign reload     = (mode != mode_q);
  assign led_onehot = (led_out != '0) && ((led_out & (led_out - LED_WIDTH'(1))) == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_out  <= LED_WIDTH'(1);
      tick_out <= 1'b0;
      dir      <= DIR_LEFT;
      count    <= '0;
      mode_q   <= MODE_ROL;
      step_q   <= 1'b0;
`ifdef LED_PATTERN_GRAY_EN
      cnt      <= '0;
`endif
    end else begin
      step_q <= step;
      mode_q <= mode;
      if (reload) begin
        // A mode change restarts the pattern and the prescaler; any coincident update is dropped.
        count    <= '0;
        tick_out <= 1'b0;
        dir      <= DIR_LEFT;
        led_out  <= (mode == MODE_COUNT) ? '0 : LED_WIDTH'(1);
`ifdef LED_PATTERN_GRAY_EN
        cnt      <= '0;
`endif
      end else begin
        if (enable) begin
          count <= tick_int ? '0 : count + CW'(1);
        end
        tick_out <= update;
        if (update) begin
          case (mode_q)
            MODE_ROL: led_out <= {led_out[LED_WIDTH-2:0], led_out[LED_WIDTH-1]};
            MODE_ROR: led_out <= {led_out[0], led_out[LED_WIDTH-1:1]};
            MODE_BOUNCE: begin
              if (!led_onehot) begin
                led_out <= LED_WIDTH'(1);
                dir     <= DIR_LEFT;
              end else if (dir == DIR_LEFT) begin
                // Turn around at the end in the same update so the endpoint is not repeated.
                if (led_out[LED_WIDTH-1]) begin
                  led_out <= led_out >> 1;
                  dir     <= DIR_RIGHT;
                end else begin
                  led_out <= led_out << 1;
                end
              end else begin
                if (led_out[0]) begin
                  led_out <= led_out << 1;
                  dir     <= DIR_LEFT;
                end else begin
                  led_out <= led_out >> 1;
                end
              end
            end
            MODE_COUNT: begin
`ifdef LED_PATTERN_GRAY_EN
              cnt     <= cnt_inc;
              led_out <= cnt_inc ^ (cnt_inc >> 1);
`else
              led_out <= led_out + LED_WIDTH'(1);
`endif
            end
            default: led_out <= led_out;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Bench for led_pattern_engine (8 LEDs, PERIOD 40): directed vector table, hand sequences,
// then randomized stimulus against a pattern-level reference model.
module tb_led_pattern_engine;

  localparam int W = 8;

  logic         clk;
  logic         reset_n;
  logic         enable;
  logic [1:0]   mode;
  logic [1:0]   speed_sel;
  logic         step;
  logic [W-1:0] led_out;
  logic         tick_out;

  int n_vec = 0;
  int n_bad = 0;

  led_pattern_engine #(
    .LED_WIDTH(W),
    .CLK_FREQ_HZ(40),
    .TICK_HZ(1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .mode(mode),
    .speed_sel(speed_sel),
    .step(step),
    .led_out(led_out),
    .tick_out(tick_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // vector table
  typedef struct {
    logic         en;
    logic [1:0]   md;
    logic [1:0]   spd;
    logic         stp;
    int           n;
    logic [W-1:0] led;
    logic         tick;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic en, input logic [1:0] md, input logic [1:0] spd,
                              input logic stp, input int n, input logic [W-1:0] led,
                              input logic tick);
    vec_t v;
    v.en = en; v.md = md; v.spd = spd; v.stp = stp; v.n = n; v.led = led; v.tick = tick;
    vq.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: pattern position/phase/count plus enabled cycles since the last tick
  int   m_mode_q;
  int   m_elapsed;
  int   m_pos;
  int   m_phase;
  int   m_cnt;
  bit   m_step_q;
  logic [W-1:0] m_led;
  bit   m_tick;

  function automatic logic [W-1:0] model_led();
    int p;
    case (m_mode_q)
      0, 1: return W'(1 << m_pos);
      2: begin
        p = (m_phase < W) ? m_phase : (2 * W - 2 - m_phase);
        return W'(1 << p);
      end
      default: return W'(m_cnt);
    endcase
  endfunction

  function automatic void model_reset();
    m_mode_q = 0; m_elapsed = 0; m_pos = 0; m_phase = 0; m_cnt = 0;
    m_step_q = 0; m_tick = 0;
    m_led = model_led();
  endfunction

  function automatic void model_clock(input bit en, input int md, input int spd, input bit stp);
    int per;
    bit fire;
    bit rise;
    per  = 40 >> spd;
    rise = stp && !m_step_q;
    m_step_q = stp;
    if (md != m_mode_q) begin
      m_mode_q = md; m_elapsed = 0; m_pos = 0; m_phase = 0; m_cnt = 0; m_tick = 0;
    end else begin
      fire = en && (m_elapsed >= per - 1);
      if (en) m_elapsed = fire ? 0 : m_elapsed + 1;
      m_tick = fire || rise;
      if (m_tick) begin
        case (md)
          0: m_pos = (m_pos + 1) % W;
          1: m_pos = (m_pos + W - 1) % W;
          2: m_phase = (m_phase + 1) % (2 * W - 2);
          default: m_cnt = (m_cnt + 1) % (1 << W);
        endcase
      end
    end
    m_led = model_led();
  endfunction

  initial begin
    int p;
    // 1: rotate-left from reset at speed 0
    add(1, 0, 0, 0, 40, 8'h02, 1);
    add(1, 0, 0, 0, 1,  8'h02, 0);
    add(1, 0, 0, 0, 39, 8'h04, 1);
    add(1, 0, 0, 0, 40, 8'h08, 1);
    add(1, 0, 0, 0, 40, 8'h10, 1);
    add(1, 0, 0, 0, 40, 8'h20, 1);
    add(1, 0, 0, 0, 40, 8'h40, 1);
    add(1, 0, 0, 0, 40, 8'h80, 1);
    add(1, 0, 0, 0, 40, 8'h01, 1);
    // 2: bounce at speed 3 after a reload
    add(1, 2, 3, 0, 1, 8'h01, 0);
    for (int k = 1; k <= 15; k++) begin
      p = k % 14;
      add(1, 2, 3, 0, 5, W'(1 << ((p < W) ? p : 14 - p)), 1);
    end
    // 3: binary count through the wrap
    add(1, 3, 3, 0, 1, 8'h00, 0);
    for (int k = 1; k <= 256; k++) add(1, 3, 3, 0, 5, W'(k), 1);
    // 4: paused prescaler, single step, prescaler resumes where it was
    add(0, 3, 3, 0, 100, 8'h00, 0);
    add(0, 3, 3, 1, 1, 8'h01, 1);
    add(0, 3, 3, 1, 1, 8'h01, 0);
    add(0, 3, 3, 1, 1, 8'h01, 0);
    add(0, 3, 3, 0, 1, 8'h01, 0);
    add(1, 3, 3, 0, 4, 8'h01, 0);
    add(1, 3, 3, 0, 1, 8'h02, 1);
    // 5: mode change mid-count reloads and clears the prescaler
    add(1, 0, 0, 0, 1, 8'h01, 0);
    add(1, 0, 0, 0, 160, 8'h10, 1);
    add(1, 0, 0, 0, 20, 8'h10, 0);
    add(1, 1, 0, 0, 1, 8'h01, 0);
    add(1, 1, 0, 0, 39, 8'h01, 0);
    add(1, 1, 0, 0, 1, 8'h80, 1);

    reset_n = 1'b0; enable = 1'b1; mode = 2'd0; speed_sel = 2'd0; step = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_led", led_out, 8'h01);
    check("reset_tick", tick_out, 1'b0);
    reset_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      enable = vq[i].en; mode = vq[i].md; speed_sel = vq[i].spd; step = vq[i].stp;
      repeat (vq[i].n) @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_led", i), led_out, vq[i].led);
      check($sformatf("vec%0d_tick", i), tick_out, vq[i].tick);
    end

    // 6: asynchronous reset mid-period, then first update a full period after release
    repeat (20) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_led", led_out, 8'h01);
    check("async_reset_tick", tick_out, 1'b0);
    mode = 2'd0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (39) @(posedge clk);
    @(negedge clk);
    check("post_reset_wait_led", led_out, 8'h01);
    check("post_reset_wait_tick", tick_out, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("post_reset_first_led", led_out, 8'h02);
    check("post_reset_first_tick", tick_out, 1'b1);

    // randomized run against the reference model
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) speed_sel = 2'($urandom_range(0, 3));
      enable = ($urandom_range(0, 9) != 0);
      step = ($urandom_range(0, 5) == 0);
      @(posedge clk);
      model_clock(enable, int'(mode), int'(speed_sel), step);
      @(negedge clk);
      check($sformatf("rand%0d_led", c), led_out, m_led);
      check($sformatf("rand%0d_tick", c), tick_out, m_tick);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
